// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader.
// The optional checksum state is selected in the top by IMEM_LOADER_CKSUM_EN.
package imem_loader_pkg;

    localparam int DEF_DEPTH      = 32;
    localparam int DEF_ADDR_W     = 5;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CKSUM,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    // States in which a stream byte may be taken.
    function automatic logic st_ready(input state_t s);
        return (s == S_COUNT) || (s == S_DATA) || (s == S_CKSUM);
    endfunction

    // States in which the core must be stalled.
    function automatic logic st_hold(input state_t s);
        return (s == S_COUNT) || (s == S_DATA) || (s == S_CKSUM) ||
               (s == S_DRAIN) || (s == S_ERR);
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: shifts stream bytes MSB-first into a 32-bit word and flags
// the byte that completes it.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d;

    // Next byte index and assembly register; clr restarts at byte 0.
    always_comb begin
        idx_d = idx_q;
        asm_d = asm_q;
        if (clr) begin
            idx_d = 2'd0;
            asm_d = 32'd0;
        end else if (in_valid) begin
            idx_d = idx_q + 2'd1;
            asm_d = {asm_q[23:0], in_byte};
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= 2'd0;
            asm_q <= 32'd0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

    assign word_valid = in_valid && !clr && (idx_q == 2'(BYTES_PER_WORD - 1));
    assign word       = {asm_q[23:0], in_byte};

endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte stream (count N, then 4*N big-endian
// data bytes) and writes the words to instruction memory from address 0
// while holding the core. Define IMEM_LOADER_CKSUM_EN to require a trailing
// XOR checksum byte over the count and data bytes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    state_t            state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, hold_q, done_q, err_q;
`ifdef IMEM_LOADER_CKSUM_EN
    logic [7:0]        cksum_q, cksum_d;
`endif

    logic        xfer;
    logic        pk_valid;
    logic [31:0] pk_word;
    logic        last_word;

    // byte_ready is a registered decode of state, so the handshake never
    // depends combinationally on byte_valid.
    assign xfer      = byte_valid && ready_q;
    assign last_word = (int'(widx_q) == int'(n_q) - 1);

    word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_q != S_DATA),
        .in_valid   (xfer && (state_q == S_DATA)),
        .in_byte    (byte_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    // Frame sequencing, word index and write register.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        widx_d  = widx_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef IMEM_LOADER_CKSUM_EN
        cksum_d = cksum_q;
`endif
        case (state_q)
            S_IDLE: if (start) state_d = S_COUNT;
            S_COUNT: if (xfer) begin
                n_d    = byte_data;
                widx_d = '0;
`ifdef IMEM_LOADER_CKSUM_EN
                cksum_d = byte_data;
                if (byte_data == 8'd0)            state_d = S_CKSUM;
`else
                if (byte_data == 8'd0)            state_d = S_DONE;
`endif
                else if (int'(byte_data) > DEPTH) state_d = S_ERR;
                else                              state_d = S_DATA;
            end
            S_DATA: if (xfer) begin
`ifdef IMEM_LOADER_CKSUM_EN
                cksum_d = cksum_q ^ byte_data;
`endif
                if (pk_valid) begin
                    we_d    = 1'b1;
                    addr_d  = widx_q;
                    wdata_d = pk_word;
                    widx_d  = widx_q + ADDR_W'(1);
`ifdef IMEM_LOADER_CKSUM_EN
                    if (last_word) state_d = S_CKSUM;
`else
                    if (last_word) state_d = S_DRAIN;
`endif
                end
            end
`ifdef IMEM_LOADER_CKSUM_EN
            S_CKSUM: if (xfer) state_d = (byte_data == cksum_q) ? S_DRAIN : S_ERR;
`endif
            S_DRAIN: state_d = S_DONE;
            S_DONE:  if (start) state_d = S_COUNT;
            S_ERR:   if (start) state_d = S_COUNT;
            default: state_d = S_IDLE;
        endcase
    end

    // All state and outputs; status outputs track the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            n_q     <= 8'd0;
            widx_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            widx_q  <= widx_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= st_ready(state_d);
            hold_q  <= st_hold(state_d);
            done_q  <= (state_d == S_DONE);
            err_q   <= (state_d == S_ERR);
`ifdef IMEM_LOADER_CKSUM_EN
            cksum_q <= cksum_d;
`endif
        end
    end

    assign byte_ready = ready_q;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frames against a frame-level reference model.
// Build with IMEM_LOADER_CKSUM_EN defined to exercise the checksum variant.
module tb_imem_loader;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
`ifdef IMEM_LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int                due;
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst, start, byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready, imem_we, cpu_hold, load_done, load_err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    wr_t         expq[$];
    logic [31:0] seen[$];

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle compare: every write must land exactly on its due cycle.
    always @(negedge clk) begin
        if (!rst) begin
            while (expq.size() > 0 && expq[0].due < cyc) begin
                chk("write_missed_due", expq[0].due, cyc);
                void'(expq.pop_front());
            end
            if (expq.size() > 0 && expq[0].due == cyc) begin
                chk("imem_we", imem_we, 1);
                chk("imem_addr", imem_addr, expq[0].a);
                chk("imem_wdata", imem_wdata, expq[0].d);
                void'(expq.pop_front());
            end else begin
                chk("no_write", imem_we, 0);
            end
            if (imem_we) seen.push_back(imem_wdata);
            chk("done_vs_hold", load_done & cpu_hold, 0);
            chk("ready_vs_hold", byte_ready & ~cpu_hold, 0);
            chk("done_vs_err", load_done & load_err, 0);
        end
    end

    task automatic wait_until(input int c);
        int w = 0;
        while (cyc < c && w < 1000) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("hold_after_start", cpu_hold, 1);
        chk("ready_after_start", byte_ready, 1);
        chk("done_cleared", load_done, 0);
        chk("err_cleared", load_err, 0);
    endtask

    // Offer one byte after 'gap' idle cycles; tcyc is the cycle right after it transfers.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse, output int tcyc);
        int w = 0;
        for (int i = 0; i < gap; i++) begin
            byte_valid = 1'b0;
            byte_data  = 8'($urandom);
            @(negedge clk);
        end
        byte_valid = 1'b1;
        byte_data  = b;
        start      = pulse;
        while (!byte_ready && w < 20) begin
            @(negedge clk);
            start = 1'b0;
            w++;
        end
        chk("byte_accepted", byte_ready, 1);
        tcyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    function automatic bq_t mk_frame(input int n, input bit corrupt);
        bq_t        f;
        logic [7:0] x;
        logic [7:0] b;
        f.push_back(8'(n));
        x = 8'(n);
        if (n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                f.push_back(b);
                x = x ^ b;
            end
            if (CK) f.push_back(corrupt ? ~x : x);
        end
        return f;
    endfunction

    // Reference: decide consumed bytes, expected writes and outcome from the frame.
    task automatic run_frame(input bq_t f, input int gmin, input int gmax, input bit inj);
        int         n    = int'(f[0]);
        bit         over = (n > DEPTH);
        int         used = over ? 1 : 1 + 4 * n + (CK ? 1 : 0);
        int         t    = 0;
        int         lat;
        bit         bad;
        logic [7:0] x    = 8'h00;
        for (int i = 0; i < used - ((CK && !over) ? 1 : 0); i++) x = x ^ f[i];
        bad = over || (CK && (f[used-1] != x));
        do_start();
        for (int i = 0; i < used; i++) begin
            send_byte(f[i], $urandom_range(gmax, gmin), inj && (i > 0) && ($urandom_range(0, 1) == 0), t);
            if (!over && i >= 4 && i <= 4 * n && (i % 4 == 0))
                expq.push_back('{t, ADDR_W'(i / 4 - 1), {f[i-3], f[i-2], f[i-1], f[i]}});
        end
        byte_valid = 1'b0;
        if (bad) begin
            wait_until(t);
            chk("err_set", load_err, 1);
            chk("err_hold", cpu_hold, 1);
            chk("err_ready", byte_ready, 0);
            chk("err_no_done", load_done, 0);
            wait_until(t + 3);
            chk("err_stays", load_err, 1);
            chk("err_hold_stays", cpu_hold, 1);
        end else begin
            lat = (n == 0 && !CK) ? 1 : 2;
            if (lat == 2) begin
                wait_until(t);
                chk("drain_no_done", load_done, 0);
                chk("drain_hold", cpu_hold, 1);
                chk("drain_ready", byte_ready, 0);
            end
            wait_until(t + lat - 1);
            chk("done_set", load_done, 1);
            chk("done_hold_low", cpu_hold, 0);
            chk("done_no_err", load_err, 0);
            chk("done_ready_low", byte_ready, 0);
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        bq_t        base;
        bq_t        f;
        logic [7:0] x;
        int         t;
        int         n;
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_ready", byte_ready, 0);
        chk("rst_we", imem_we, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", load_done, 0);
        chk("rst_err", load_err, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        start = 1'b1;                 // start together with reset: reset wins
        @(negedge clk);
        start = 1'b0;
        chk("rst_beats_start", cpu_hold, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_hold", cpu_hold, 0);
        chk("idle_ready", byte_ready, 0);

        base = '{8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        x = 8'h00;
        foreach (base[i]) x = x ^ base[i];
        if (CK) base.push_back(x);

        // Directed frame at full rate, then with byte_valid toggling.
        for (int k = 0; k < 2; k++) begin
            seen.delete();
            run_frame(base, k, k, 1'b0);
            chk("dir_nwords", seen.size(), 2);
            if (seen.size() == 2) begin
                chk("dir_word0", seen[0], 32'h24080005);
                chk("dir_word1", seen[1], 32'h8C090004);
            end
        end

        // Oversized count, then recovery via start.
        run_frame(mk_frame(33, 1'b0), 0, 0, 1'b0);
        run_frame(mk_frame(255, 1'b0), 0, 1, 1'b0);
        run_frame(mk_frame(0, 1'b0), 0, 0, 1'b0);
        run_frame(mk_frame(DEPTH, 1'b0), 0, 0, 1'b0);
        run_frame(mk_frame(1, 1'b0), 0, 2, 1'b1);

        // Wrong checksum: both words still written, then error.
        if (CK) begin
            f = base;
            f[f.size()-1] = 8'hFF;
            seen.delete();
            run_frame(f, 0, 0, 1'b0);
            chk("bad_ck_nwords", seen.size(), 2);
        end

        // Start pulses while loading are ignored.
        seen.delete();
        run_frame(base, 0, 1, 1'b1);
        chk("inj_nwords", seen.size(), 2);

        // Reset after 6 data bytes: word 0 written, word 1 dropped.
        do_start();
        for (int i = 0; i < 7; i++) begin
            send_byte(base[i], 0, 1'b0, t);
            if (i == 4) expq.push_back('{t, ADDR_W'(0), 32'h24080005});
        end
        rst = 1'b1;
        byte_valid = 1'b0;
        #1;
        chk("mid_rst_ready", byte_ready, 0);
        chk("mid_rst_we", imem_we, 0);
        chk("mid_rst_hold", cpu_hold, 0);
        chk("mid_rst_done", load_done, 0);
        chk("mid_rst_err", load_err, 0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_wdata", imem_wdata, 0);
        chk("mid_rst_pending", expq.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized frames.
        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 9))
                0:       n = 0;
                1:       n = DEPTH;
                2:       n = DEPTH + 1 + int'($urandom_range(0, 200));
                3:       n = int'($urandom_range(1, DEPTH));
                default: n = int'($urandom_range(1, 6));
            endcase
            run_frame(mk_frame(n, CK && ($urandom_range(0, 3) == 0)), 0,
                      int'($urandom_range(0, 2)), $urandom_range(0, 1) == 1);
        end
        repeat (3) @(negedge clk);
        chk("final_pending", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
